// File: rtl/coreport_infilter_if.sv
// rtl/coreport_infilter_if.sv - pin-side and port-side signal bundle for the GPIO input filter
interface coreport_infilter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   pin_i;
  logic [WIDTH-1:0]   bypass_i;
  logic [2*WIDTH-1:0] edge_mode_i;
  logic [WIDTH-1:0]   data_o;
  logic [WIDTH-1:0]   edge_o;
  logic               edge_any_o;

  modport master (
    output pin_i,
    output bypass_i,
    output edge_mode_i,
    input  data_o,
    input  edge_o,
    input  edge_any_o
  );

  modport slave (
    input  pin_i,
    input  bypass_i,
    input  edge_mode_i,
    output data_o,
    output edge_o,
    output edge_any_o
  );
endinterface

// File: rtl/coreport_infilter.sv
// rtl/coreport_infilter.sv - GPIO input synchronizer, per-bit debouncer and edge-pulse generator
module coreport_infilter #(
  parameter int               WIDTH           = 8,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0] INITIAL_LEVEL   = '0
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  coreport_infilter_if.slave   gpio
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_last;
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_d;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= gpio.pin_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  // A mismatch must persist for DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
  always_comb begin
    data_d = data_q;
    edge_d = '0;
    for (int n = 0; n < WIDTH; n++) begin
      cnt_d[n] = '0;
      if (gpio.bypass_i[n]) begin
        data_d[n] = sync_last[n];
      end else if (sync_last[n] != data_q[n]) begin
        if (cnt_q[n] == CNT_LAST) begin
          data_d[n] = sync_last[n];
        end else begin
          cnt_d[n] = cnt_q[n] + CNT_W'(1);
        end
      end
      // Edge mode is sampled on the same edge that commits the level change.
      edge_d[n] = (data_d[n] & ~data_q[n] & gpio.edge_mode_i[2*n])
                | (~data_d[n] & data_q[n] & gpio.edge_mode_i[2*n+1]);
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      data_q <= INITIAL_LEVEL;
      edge_q <= '0;
      for (int n = 0; n < WIDTH; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      data_q <= data_d;
      edge_q <= edge_d;
      for (int n = 0; n < WIDTH; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  assign gpio.data_o     = data_q;
  assign gpio.edge_o     = edge_q;
  assign gpio.edge_any_o = |edge_q;

endmodule

// File: tb/tb_coreport_infilter.sv
// tb/tb_coreport_infilter.sv - scoreboard bench for coreport_infilter against a sliding-window reference
module tb_coreport_infilter;
  localparam int         W    = 8;
  localparam int         S    = 2;
  localparam int         D    = 4;
  localparam logic [7:0] INIT = 8'h00;

  logic wb_clk   = 1'b0;
  logic wb_rst_n = 1'b0;

  always #5 wb_clk = ~wb_clk;

  coreport_infilter_if #(.WIDTH(W)) gpio ();

  coreport_infilter #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .INITIAL_LEVEL(INIT)
  ) dut (
    .wb_clk  (wb_clk),
    .wb_rst_n(wb_rst_n),
    .gpio    (gpio)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q [$];
  logic [7:0]  pipe  [$];
  logic [7:0]  shist [$];
  logic [7:0]  m_data;
  logic [7:0]  m_edge;

  function automatic void chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    pipe.delete();
    for (int i = 0; i < S; i++) pipe.push_back(8'h00);
    shist.delete();
    m_data = INIT;
    m_edge = 8'h00;
  endfunction

  // A level is accepted once the last D synchronized samples all show it.
  task automatic model_step();
    logic [7:0] s, nd, and_w, or_w, rise_m, fall_m;
    if (!wb_rst_n) begin
      model_reset();
    end else begin
      s = pipe[S-1];
      pipe.push_front(gpio.pin_i);
      void'(pipe.pop_back());
      shist.push_back(s);
      if (shist.size() > D) void'(shist.pop_front());
      and_w = 8'hFF;
      or_w  = 8'h00;
      foreach (shist[i]) begin
        and_w = and_w & shist[i];
        or_w  = or_w | shist[i];
      end
      nd = m_data;
      for (int n = 0; n < W; n++) begin
        rise_m[n] = gpio.edge_mode_i[2*n];
        fall_m[n] = gpio.edge_mode_i[2*n+1];
        if (gpio.bypass_i[n]) nd[n] = s[n];
        else if (shist.size() == D) begin
          if (!m_data[n] && and_w[n]) nd[n] = 1'b1;
          else if (m_data[n] && !or_w[n]) nd[n] = 1'b0;
        end
      end
      m_edge = (nd & ~m_data & rise_m) | (~nd & m_data & fall_m);
      m_data = nd;
    end
    exp_q.push_back({m_data, m_edge});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge wb_clk);
      model_step();
      @(negedge wb_clk);
    end
  endtask

  task automatic do_reset();
    #2 wb_rst_n = 1'b0;
    #1;
    chk("rst_data", gpio.data_o, INIT);
    chk("rst_edge", gpio.edge_o, 8'h00);
    chk("rst_any", {7'b0, gpio.edge_any_o}, 8'h00);
    tick(2);
    #2 wb_rst_n = 1'b1;
  endtask

  task automatic measure(input int b, input logic lvl, input int exp_n, input string name);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    while (k < 20 && !seen) begin
      tick(1);
      k++;
      if (gpio.data_o[b] === lvl) seen = 1'b1;
    end
    checks++;
    if (!seen || k != exp_n) begin
      failures++;
      $display("FAIL %s latency got=%0d exp=%0d", name, k, exp_n);
    end
  endtask

  always @(negedge wb_clk) begin
    logic [15:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_data_o", gpio.data_o, e[15:8]);
      chk("sb_edge_o", gpio.edge_o, e[7:0]);
      chk("sb_edge_any_o", {7'b0, gpio.edge_any_o}, {7'b0, |e[7:0]});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t;
    gpio.pin_i       = 8'h00;
    gpio.bypass_i    = 8'h00;
    gpio.edge_mode_i = 16'h0000;
    model_reset();
    #1;
    chk("init_data", gpio.data_o, INIT);
    chk("init_edge", gpio.edge_o, 8'h00);
    chk("init_any", {7'b0, gpio.edge_any_o}, 8'h00);
    @(negedge wb_clk);
    #2 wb_rst_n = 1'b1;
    tick(3);

    // Test 1: debounced rise on bit 0, rising-only mode
    gpio.edge_mode_i = 16'h0001;
    gpio.pin_i = 8'h01;
    measure(0, 1'b1, 6, "t1_latency");
    chk("t1_edge", gpio.edge_o, 8'h01);
    chk("t1_any", {7'b0, gpio.edge_any_o}, 8'h01);
    tick(1);
    chk("t1_edge_clear", gpio.edge_o, 8'h00);
    gpio.pin_i = 8'h00;
    tick(8);

    // Test 2: 3-cycle glitch on bit 1
    gpio.edge_mode_i = 16'h000C;
    gpio.pin_i = 8'h02;
    tick(3);
    gpio.pin_i = 8'h00;
    tick(6);
    chk("t2_data", gpio.data_o, 8'h00);
    chk("t2_cnt", 8'(dut.cnt_q[1]), 8'h00);

    // Test 3: bypass on bit 2, falling-only mode
    gpio.bypass_i = 8'h04;
    gpio.edge_mode_i = 16'h0020;
    gpio.pin_i = 8'h04;
    measure(2, 1'b1, 3, "t3_rise_latency");
    chk("t3_rise_edge", gpio.edge_o, 8'h00);
    tick(1);
    gpio.pin_i = 8'h00;
    measure(2, 1'b0, 3, "t3_fall_latency");
    chk("t3_fall_edge", gpio.edge_o, 8'h04);
    tick(1);
    for (int i = 0; i < 4; i++) begin
      gpio.pin_i = gpio.pin_i ^ 8'h04;
      tick(4);
    end
    gpio.bypass_i = 8'h00;
    tick(2);

    // Test 4: all bits together, both edges
    gpio.edge_mode_i = 16'hFFFF;
    gpio.pin_i = 8'hFF;
    measure(7, 1'b1, 6, "t4_latency");
    chk("t4_data", gpio.data_o, 8'hFF);
    chk("t4_edge", gpio.edge_o, 8'hFF);
    tick(1);
    chk("t4_edge_once", gpio.edge_o, 8'h00);
    gpio.pin_i = 8'h00;
    tick(8);

    // Test 5: reset in the middle of a debounce on bit 3
    gpio.edge_mode_i = 16'h00C0;
    gpio.pin_i = 8'h08;
    tick(4);
    do_reset();
    measure(3, 1'b1, 6, "t5_after_reset");
    gpio.pin_i = 8'h00;
    tick(8);

    // Test 6: mode 00 suppresses pulses on bit 4
    gpio.edge_mode_i = 16'h0000;
    gpio.pin_i = 8'h10;
    measure(4, 1'b1, 6, "t6_latency");
    chk("t6_edge", gpio.edge_o, 8'h00);
    gpio.pin_i = 8'h00;
    tick(8);

    for (int c = 0; c < 1500; c++) begin
      t = 8'h00;
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, 5) == 0) t[b] = 1'b1;
      end
      gpio.pin_i = gpio.pin_i ^ t;
      if (c % 50 == 0) gpio.edge_mode_i = 16'($urandom);
      if (c % 64 == 0) gpio.bypass_i = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 399) == 0) do_reset();
      else tick(1);
    end
    tick(2);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
